// File: rtl/matrix_keypad_scanner_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// The FSM state encoding is exported so debug ports and benches can name the states.
package kp_pkg;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} kp_state_t;

  // Width of a code able to index n keys; never narrower than one bit.
  function automatic int kp_cw(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/matrix_keypad_scanner_if.sv
// Pin-side and event-side signals of the keypad scanner, plus the FSM state for observation.
// key_valid and multi_key are single-cycle strobes with no back-pressure: a consumer must take them when seen.
interface matrix_keypad_scanner_if
  import kp_pkg::*;
#(
  parameter int NROWS = 4,
  parameter int NCOLS = 4
);

  localparam int CW = kp_cw(NROWS * NCOLS);

  logic [NROWS-1:0] rows_in;
  logic [NCOLS-1:0] col_drive;
  logic             key_valid;
  logic [CW-1:0]    key_code;
  logic             key_held;
  logic             multi_key;
  kp_state_t        state;

  modport master (
    input  rows_in,
    output col_drive, key_valid, key_code, key_held, multi_key, state
  );

  modport slave (
    output rows_in,
    input  col_drive, key_valid, key_code, key_held, multi_key, state
  );

endinterface

// File: rtl/matrix_keypad_scanner_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs; output lags the pins by two clocks.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Column-scanning keypad front end: debounced press/release, one-key lockout,
// multi-key detection and optional auto-repeat of the held key.
module matrix_keypad_scanner
  import kp_pkg::*;
#(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SCAN_DIV        = 15,
  parameter int DEBOUNCE_CYCLES = 150000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000
) (
  input  logic                    clk,
  input  logic                    reset,
  matrix_keypad_scanner_if.master bus
);

  localparam int CW   = kp_cw(NROWS * NCOLS);
  localparam int COLW = kp_cw(NCOLS);
  localparam int RBW  = kp_cw(NROWS);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPW  = $clog2(RMAX + 1);

  logic [NROWS-1:0] rows_s;
  kp_state_t        state_q, state_d;
  logic [COLW-1:0]  col_q, col_d, col_next;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [DBW-1:0]   deb_q, deb_d;
  logic [RPW-1:0]   rep_q, rep_d, rep_tgt;
  logic             rep_first_q, rep_first_d;
  logic [RBW-1:0]   row_q, row_d, first_row;
  logic [CW-1:0]    code_q, code_d;
  logic             valid_q, valid_d, held_q, held_d, multi_q, multi_d;
  logic [NROWS-1:0] row_mask;
  logic [NCOLS-1:0] col_oh;
  logic             row_hit, others_hit;
  int               n_high;

  sync_2ff #(.W(NROWS)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.rows_in),
    .q    (rows_s)
  );

  always_comb begin
    row_mask        = '0;
    row_mask[row_q] = 1'b1;
    col_oh          = '0;
    col_oh[col_q]   = 1'b1;
    first_row       = '0;
    for (int i = 0; i < NROWS; i++) begin
      if (rows_s[i]) first_row = RBW'(i);
    end
  end

  assign n_high     = $countones(rows_s);
  assign row_hit    = rows_s[row_q];
  assign others_hit = |(rows_s & ~row_mask);
  assign col_next   = (col_q == COLW'(NCOLS - 1)) ? '0 : col_q + 1'b1;
  assign rep_tgt    = rep_first_q ? RPW'(REPEAT_DELAY - 1) : RPW'(REPEAT_PERIOD - 1);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    row_d       = row_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    held_d      = held_q;
    multi_d     = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          if (n_high == 0) begin
            col_d = col_next;
          end else if (n_high == 1) begin
            row_d   = first_row;
            deb_d   = '0;
            state_d = DEB_PRESS;
          end else begin
            multi_d = 1'b1;
            col_d   = col_next;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (row_hit && !others_hit) begin
          if (deb_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            valid_d     = 1'b1;
            held_d      = 1'b1;
            code_d      = CW'(int'(row_q) * NCOLS + int'(col_q));
            rep_d       = '0;
            rep_first_d = 1'b1;
            state_d     = HELD;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          col_d   = col_next;
          dwell_d = '0;
        end
      end
      HELD: begin
        if (REPEAT_EN != 0 && rep_q >= rep_tgt) begin
          valid_d     = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b0;
        end else if (rep_q < rep_tgt) begin
          rep_d = rep_q + 1'b1;
        end
        if (!row_hit) begin
          deb_d   = '0;
          state_d = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        // Repeat time keeps running; a repeat falling due here waits for the return to HELD.
        if (rep_q < rep_tgt) rep_d = rep_q + 1'b1;
        if (row_hit) begin
          state_d = HELD;
        end else if (deb_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
          held_d  = 1'b0;
          state_d = SCAN;
          col_d   = col_next;
          dwell_d = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_q       <= '0;
      dwell_q     <= '0;
      deb_q       <= '0;
      rep_q       <= '0;
      rep_first_q <= 1'b0;
      row_q       <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
      row_q       <= row_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
      multi_q     <= multi_d;
    end
  end

  assign bus.col_drive = col_oh;
  assign bus.key_valid = valid_q;
  assign bus.key_code  = code_q;
  assign bus.key_held  = held_q;
  assign bus.multi_key = multi_q;
  assign bus.state     = state_q;

endmodule
